// File: rtl/eth_act_led.sv
// eth_act_led: turns RX/TX activity strobes and link status into LED drive
// signals, and keeps a saturating count of activity strobes for debug.
module eth_act_led #(
  parameter int unsigned ON_CYCLES  = 2_500_000,
  parameter int unsigned OFF_CYCLES = 2_500_000,
  parameter int unsigned SLOW_HALF  = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_act,
  input  logic        tx_act,
  input  logic        link_up,
  input  logic        evt_clr,
  output logic        led_act,
  output logic        led_link,
  output logic [15:0] evt_cnt
);

  localparam logic [25:0] ON_LOAD   = 26'(ON_CYCLES - 1);
  localparam logic [25:0] OFF_LOAD  = 26'(OFF_CYCLES - 1);
  localparam logic [25:0] SLOW_LOAD = 26'(SLOW_HALF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF
  } act_state_t;

  act_state_t  state;
  logic        pend;
  logic        act;
  logic [25:0] act_tmr;
  logic [25:0] slow_tmr;
  logic        link_q;
  logic [16:0] evt_sum;

  always_comb begin
    act     = (rx_act | tx_act) & link_up;
    evt_sum = {1'b0, evt_cnt} + 17'(rx_act) + 17'(tx_act);
  end

  // Activity blink FSM: ON for ON_CYCLES, then at least OFF_CYCLES dark;
  // an act on the final OFF cycle is folded into the pending decision.
  always_ff @(posedge clk) begin
    if (rst || !link_up) begin
      state   <= ST_IDLE;
      pend    <= 1'b0;
      act_tmr <= '0;
      led_act <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (act) begin
            state   <= ST_ON;
            act_tmr <= ON_LOAD;
            led_act <= 1'b1;
          end
        end
        ST_ON: begin
          if (act) pend <= 1'b1;
          if (act_tmr == '0) begin
            state   <= ST_OFF;
            act_tmr <= OFF_LOAD;
            led_act <= 1'b0;
          end else begin
            act_tmr <= act_tmr - 26'd1;
          end
        end
        ST_OFF: begin
          if (act_tmr == '0) begin
            if (pend || act) begin
              state   <= ST_ON;
              act_tmr <= ON_LOAD;
              led_act <= 1'b1;
              pend    <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            act_tmr <= act_tmr - 26'd1;
            if (act) pend <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          pend    <= 1'b0;
          act_tmr <= '0;
          led_act <= 1'b0;
        end
      endcase
    end
  end

  // Link LED: solid when up, slow blink starting dark when down.
  // link_q resets high so a link that is already down out of reset is
  // treated as a fresh falling edge and starts a full dark half-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_link <= 1'b0;
      slow_tmr <= '0;
      link_q   <= 1'b1;
    end else begin
      link_q <= link_up;
      if (link_up) begin
        led_link <= 1'b1;
        slow_tmr <= '0;
      end else if (link_q) begin
        led_link <= 1'b0;
        slow_tmr <= SLOW_LOAD;
      end else if (slow_tmr == '0) begin
        led_link <= ~led_link;
        slow_tmr <= SLOW_LOAD;
      end else begin
        slow_tmr <= slow_tmr - 26'd1;
      end
    end
  end

  // Saturating event counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || evt_clr) begin
      evt_cnt <= '0;
    end else if (link_up) begin
      evt_cnt <= evt_sum[16] ? '1 : evt_sum[15:0];
    end
  end

endmodule

// File: tb/tb_eth_act_led.sv
// tb_eth_act_led: directed checks of blink timing, pending blink, link drop,
// slow link blink, reset mid-blink and event counter saturation/clear.
module tb_eth_act_led;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_act;
  logic        tx_act;
  logic        link_up;
  logic        evt_clr;
  logic        led_act;
  logic        led_link;
  logic [15:0] evt_cnt;

  int unsigned cyc;
  int unsigned total;
  int unsigned bad;

  eth_act_led #(
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .SLOW_HALF (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_act  (rx_act),
    .tx_act  (tx_act),
    .link_up (link_up),
    .evt_clr (evt_clr),
    .led_act (led_act),
    .led_link(led_link),
    .evt_cnt (evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Cycle k is the interval just after edge k; inputs set in cycle k are
  // sampled at edge k+1.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input logic lnk);
    rst     = 1'b1;
    rx_act  = 1'b0;
    tx_act  = 1'b0;
    evt_clr = 1'b0;
    link_up = lnk;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;

    // 1: single blink
    do_reset(1'b1);
    check("rst_act", led_act, 0);
    check("rst_link", led_link, 0);
    check("rst_evt", evt_cnt, 0);
    while (cyc < 20) begin
      rx_act = (cyc == 10);
      tick();
      rx_act = 1'b0;
      check("t1_act", led_act, (cyc >= 11 && cyc <= 14));
      check("t1_link", led_link, 1);
      check("t1_evt", evt_cnt, (cyc >= 11) ? 1 : 0);
    end

    // 2: pending blink, back to back
    do_reset(1'b1);
    while (cyc < 30) begin
      rx_act = (cyc == 10);
      tx_act = (cyc == 12 || cyc == 16);
      tick();
      rx_act = 1'b0;
      tx_act = 1'b0;
      check("t2_act", led_act, ((cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21)));
      check("t2_evt", evt_cnt, (cyc >= 17) ? 3 : (cyc >= 13) ? 2 : (cyc >= 11) ? 1 : 0);
    end

    // 3: saturation and clear priority
    do_reset(1'b1);
    rx_act = 1'b1;
    tx_act = 1'b1;
    for (int i = 0; i < 32767; i++) tick();
    check("t3_fffe", evt_cnt, 16'hFFFE);
    tick();
    check("t3_sat", evt_cnt, 16'hFFFF);
    tick();
    check("t3_hold", evt_cnt, 16'hFFFF);
    tx_act  = 1'b0;
    evt_clr = 1'b1;
    tick();
    check("t3_clr", evt_cnt, 0);
    evt_clr = 1'b0;
    tick();
    check("t3_after", evt_cnt, 1);
    rx_act = 1'b0;

    // 4: link drop mid-blink
    do_reset(1'b1);
    while (cyc < 31) begin
      link_up = (cyc < 12);
      rx_act  = (cyc == 10 || cyc == 14 || cyc == 20);
      tx_act  = (cyc == 11);
      tick();
      rx_act = 1'b0;
      tx_act = 1'b0;
      check("t4_act", led_act, (cyc == 11 || cyc == 12));
      check("t4_link", led_link, (cyc <= 12) ? 1 : (((cyc - 13) / 5) % 2));
      check("t4_evt", evt_cnt, (cyc >= 12) ? 2 : (cyc >= 11) ? 1 : 0);
    end
    link_up = 1'b1;

    // 5: reset during ON with pend set
    do_reset(1'b1);
    while (cyc < 36) begin
      rst    = (cyc == 13);
      rx_act = (cyc == 10 || cyc == 25);
      tx_act = (cyc == 12);
      tick();
      rst    = 1'b0;
      rx_act = 1'b0;
      tx_act = 1'b0;
      check("t5_act", led_act, ((cyc >= 11 && cyc <= 13) || (cyc >= 26 && cyc <= 29)));
      check("t5_link", led_link, (cyc != 14));
      check("t5_evt", evt_cnt, (cyc >= 26) ? 1 : (cyc == 14 || cyc < 11) ? 0 :
                               (cyc >= 13) ? ((cyc >= 15) ? 0 : 2) : 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_act_led.md
# eth_act_led

Ethernet status indicator stage that converts single-cycle RGMII receive/transmit activity strobes and a link-up level into human-visible LED drive signals. It sits directly upstream of the board LED outputs, in the same clock domain as the LED blink counters. It also keeps a saturating activity-event counter for debug readout.

## Interface

**Parameters**
- `ON_CYCLES`, 2_500_000: cycles `led_act` stays lit per blink (50 ms at 50 MHz); legal range 1..2^26-1.
- `OFF_CYCLES`, 2_500_000: minimum dark cycles after each blink; legal range 1..2^26-1.
- `SLOW_HALF`, 12_500_000: half-period of the link-down blink on `led_link`; legal range 1..2^26-1.

**Ports**
- `clk`  in  1: system clock; the single clock of the block.
- `rst`  in  1: reset, synchronous and active-high.
- `rx_act`  in  1: one-cycle strobe per received frame, already synchronous to `clk`.
- `tx_act`  in  1: one-cycle strobe per transmitted frame, already synchronous to `clk`.
- `link_up`  in  1: PHY link status level, already synchronous to `clk`.
- `evt_clr`  in  1: synchronous clear of `evt_cnt`.
- `led_act`  out  1: activity LED drive, registered, 1 = lit.
- `led_link`  out  1: link LED drive, registered, 1 = lit.
- `evt_cnt`  out  16: saturating count of activity strobes.

## Operation

- `act = (rx_act | tx_act) & link_up`.
- Activity FSM states:
  - **IDLE**: `led_act` = 0. On `act`, go to ON and load the timer.
  - **ON**: `led_act` = 1 for exactly ON_CYCLES cycles, then go to OFF.
  - **OFF**: `led_act` = 0 for exactly OFF_CYCLES cycles. At expiry, go to ON if `pend` is set, clearing `pend`; otherwise go to IDLE.
- `pend` flag:
  - Set by any `act` seen while in ON or OFF, including the final OFF cycle.
  - Several events during one blink collapse into a single pending blink.
- Link drop: `link_up` = 0 forces the FSM to IDLE, clears `pend` and the timer, and drives `led_act` = 0 on the next edge.
- Link LED:
  - With `link_up` = 1, `led_link` = 1.
  - With `link_up` = 0, `led_link` toggles every SLOW_HALF cycles, starting at 0.
  - The slow counter and phase reset on every edge of `link_up`.
- Event counter:
  - Each cycle, `evt_cnt` increments by `rx_act + tx_act` (0, 1 or 2), but only while `link_up` = 1.
  - Saturates at 0xFFFF; 0xFFFE + 2 gives 0xFFFF.
  - `evt_clr` has priority over increment: the counter reads 0 after the clear edge, even if strobes are present that cycle.
- Arithmetic widths:
  - Timers are 26-bit down-counters.
  - The saturation compare uses a 17-bit sum.

## Timing

- Reset values: `led_act` = 0, `led_link` = 0, `evt_cnt` = 0, FSM = IDLE, `pend` = 0, all timers = 0. `rst` overrides every other input, including mid-blink.
- `act` sampled high at edge n while in IDLE: `led_act` = 1 after edge n.
- `led_act` returns to 0 after edge n+ON_CYCLES.
- Earliest next rise is after edge n+ON_CYCLES+OFF_CYCLES. If `pend` is set, the rise happens at exactly that edge (back-to-back blink, no extra idle cycle).
- An `act` arriving in the same cycle the FSM goes OFF→IDLE is captured: the FSM goes to ON instead, with the same timing as the pending case.
- `link_up` change to `led_link` change: 1 cycle latency.
- First link-down toggle to 1 occurs SLOW_HALF cycles after the `led_link` = 0 edge.
- `evt_cnt` reflects a strobe 1 cycle after it is sampled.

## Test plan

Bench parameters: ON_CYCLES=4, OFF_CYCLES=3, SLOW_HALF=5.

1. Reset, `link_up` = 1, single `rx_act` pulse at cycle 10 → `led_act` high for cycles 11–14, low from 15. `evt_cnt` = 1 at cycle 11. `led_link` = 1 from cycle 1.
2. `rx_act` at cycle 10, `tx_act` at cycles 12 and 16 → first blink covers cycles 11–14. Second blink starts exactly at cycle 18 and covers 18–21. No third blink. `evt_cnt` = 3.
3. `rx_act` and `tx_act` together with `evt_cnt` preloaded to 0xFFFE → `evt_cnt` = 0xFFFF and holds there. Asserting `evt_clr` together with a strobe gives 0.
4. `link_up` dropped at cycle 12, mid-blink → `led_act` = 0 at cycle 13 and no pending blink follows. `led_link` = 0 at 13 and toggles at 18, 23, 28. Strobes while the link is down do not change `evt_cnt`.
5. `rst` asserted at cycle 13 during ON with `pend` set → all outputs 0 at cycle 14 and no blink after reset release. A fresh `rx_act` then produces a normal 4-cycle blink.
